// File: rtl/axi_arb_ctrl_pkg.sv
// Shared definitions for the fetch/data AXI arbiter: FSM states and the fixed
// AXI attribute values driven on the master port.
package axi_arb_ctrl_pkg;

  // Transaction sequencer states. The read path is IDLE-AR-R-DONE and the
  // write path is IDLE-AW_W-B-DONE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam int unsigned AXI_ID_W = 4;

  // Only single-beat INCR transactions are ever issued.
  localparam logic [7:0]          AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0]          AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]          AXI_SIZE_WORD  = 3'd2;

  // Fixed transaction ids so a slave or monitor can tell the requesters apart.
  localparam logic [AXI_ID_W-1:0] AXI_ID_INST    = 4'd0;
  localparam logic [AXI_ID_W-1:0] AXI_ID_DATA    = 4'd1;

  // The requester size field already uses the AXI encoding; widen it to 3 bits.
  function automatic logic [2:0] axi_size_from_req(input logic [1:0] req_size);
    return {1'b0, req_size};
  endfunction

endpackage

// File: rtl/axi_arb_ctrl.sv
// Arbiter that shares one AXI master port between instruction fetch and
// load/store traffic. One single-beat transaction is in flight at a time;
// every AXI address/data output comes from request registers captured at
// grant, so requester inputs may change freely once a request is granted.
module axi_arb_ctrl
  import axi_arb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  // instruction fetch requester
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_data_ok,
  // load/store requester
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_data_ok,
  // shared read data and pipeline stalls
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  i_stall,
  output logic                  d_stall,
  // AXI read address channel
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arsize,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [7:0]            arlen,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data channel
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI write address channel
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic [AXI_ID_W-1:0]   awid,
  output logic [7:0]            awlen,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data channel
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response channel
  input  logic                  bvalid,
  output logic                  bready
);

  state_e                state_q,   state_d;
  logic                  owner_q,   owner_d;    // 1 = data requester owns the bus
  logic [ADDR_W-1:0]     addr_q,    addr_d;
  logic [2:0]            size_q,    size_d;
  logic [DATA_W-1:0]     wdata_q,   wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q,   wstrb_d;
  logic                  aw_pend_q, aw_pend_d;  // AW handshake still outstanding
  logic                  w_pend_q,  w_pend_d;   // W handshake still outstanding
  logic [DATA_W-1:0]     rdata_q,   rdata_d;

  // State and request registers; reset abandons any transaction in flight.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
    end
  end

  // Grant, channel handshakes and next-state sequencing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // Data access has priority when both requesters ask in the same cycle.
        if (data_req) begin
          owner_d   = 1'b1;
          addr_d    = data_addr;
          size_d    = axi_size_from_req(data_size);
          wdata_d   = data_wdata;
          wstrb_d   = data_wstrb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = data_wr ? ST_AW_W : ST_AR;
        end else if (inst_req) begin
          owner_d   = 1'b0;
          addr_d    = inst_addr;
          size_d    = AXI_SIZE_WORD;
          wstrb_d   = '0;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = ST_DONE;
        end
      end
      ST_AW_W: begin
        // AW and W complete independently, in either order or together.
        if (awready) aw_pend_d = 1'b0;
        if (wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = ST_B;
      end
      ST_B: begin
        if (bvalid) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel controls decode the registered state, so they are glitch-free and
  // all low in IDLE.
  assign arvalid = (state_q == ST_AR);
  assign rready  = (state_q == ST_R);
  assign awvalid = (state_q == ST_AW_W) && aw_pend_q;
  assign wvalid  = (state_q == ST_AW_W) && w_pend_q;
  assign bready  = (state_q == ST_B);

  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arid    = owner_q ? AXI_ID_DATA : AXI_ID_INST;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;

  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign awid    = AXI_ID_DATA;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  assign inst_data_ok = (state_q == ST_DONE) && !owner_q;
  assign data_data_ok = (state_q == ST_DONE) &&  owner_q;
  assign rdata_o      = rdata_q;

  // A requester stalls from request until its completion pulse.
  assign i_stall = !cpu_rst && inst_req && !inst_data_ok;
  assign d_stall = !cpu_rst && data_req && !data_data_ok;

endmodule

// File: tb/tb_axi_arb_ctrl.sv
// Self-checking bench for axi_arb_ctrl: directed requester scenarios, a
// programmable-latency AXI slave, and a transaction-level reference model that
// checks every DUT output on every cycle.
module tb_axi_arb_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_data_ok;
  logic [31:0] rdata_o;
  logic        i_stall, d_stall;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  axi_arb_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_data_ok(data_data_ok), .rdata_o(rdata_o),
    .i_stall(i_stall), .d_stall(d_stall),
    .araddr(araddr), .arsize(arsize), .arid(arid), .arlen(arlen),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awid(awid), .awlen(awlen),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AXI slave with per-channel ready/valid delays ----------
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int          ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
  logic [31:0] slv_rdata = 32'h0;

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    forever begin
      @(posedge cpu_clk);
      #2;
      if (cpu_rst) begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      end else begin
        if (arvalid) begin arready = (ar_c == ar_dly); ar_c++; end
        else begin arready = 1'b0; ar_c = 0; end
        if (rready) begin rvalid = (r_c == r_dly); rdata = rvalid ? slv_rdata : 32'h0; r_c++; end
        else begin rvalid = 1'b0; rdata = 32'h0; r_c = 0; end
        if (awvalid) begin awready = (aw_c == aw_dly); aw_c++; end
        else begin awready = 1'b0; aw_c = 0; end
        if (wvalid) begin wready = (w_c == w_dly); w_c++; end
        else begin wready = 1'b0; w_c = 0; end
        if (bready) begin bvalid = (b_c == b_dly); b_c++; end
        else begin bvalid = 1'b0; b_c = 0; end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------------
  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;

  int          m_phase = M_IDLE;
  txn_t        cur;
  bit          ar_done, aw_done, w_done;
  logic [31:0] exp_rdata_o = 32'h0;
  bit          exp_iok, exp_dok;
  bit          seen_w_only = 0;
  int          inst_ok_cnt = 0, data_ok_cnt = 0;
  logic [31:0] last_araddr = 32'h0, last_awaddr = 32'h0, last_wdata = 32'h0;
  logic [2:0]  last_arsize = 3'h0, last_awsize = 3'h0;
  logic [3:0]  last_wstrb = 4'h0;

  // Compare process: checks every output on the falling edge, then advances
  // the model with the handshakes that will complete on the next rising edge.
  always @(negedge cpu_clk) begin
    if (cpu_rst) begin
      chk("rst_i_stall", i_stall, 1'b0);
      chk("rst_d_stall", d_stall, 1'b0);
      m_phase     = M_IDLE;
      exp_rdata_o = 32'h0;
    end else begin
      exp_iok = (m_phase == M_DONE) && !cur.is_data;
      exp_dok = (m_phase == M_DONE) &&  cur.is_data;
      chk("inst_data_ok", inst_data_ok, exp_iok);
      chk("data_data_ok", data_data_ok, exp_dok);
      chk("i_stall", i_stall, inst_req && !exp_iok);
      chk("d_stall", d_stall, data_req && !exp_dok);
      chk("rdata_o", rdata_o, exp_rdata_o);
      if (inst_data_ok) inst_ok_cnt++;
      if (data_data_ok) data_ok_cnt++;
      case (m_phase)
        M_IDLE, M_DONE: begin
          chk("idle_arvalid", arvalid, 1'b0);
          chk("idle_rready", rready, 1'b0);
          chk("idle_awvalid", awvalid, 1'b0);
          chk("idle_wvalid", wvalid, 1'b0);
          chk("idle_bready", bready, 1'b0);
          if (m_phase == M_DONE) begin
            m_phase = M_IDLE;
          end else if (data_req) begin
            cur.is_data = 1'b1; cur.wr = data_wr; cur.addr = data_addr;
            cur.size = {1'b0, data_size}; cur.wdata = data_wdata; cur.wstrb = data_wstrb;
            ar_done = 0; aw_done = 0; w_done = 0;
            m_phase = M_BUSY;
          end else if (inst_req) begin
            cur.is_data = 1'b0; cur.wr = 1'b0; cur.addr = inst_addr;
            cur.size = 3'd2; cur.wdata = 32'h0; cur.wstrb = 4'h0;
            ar_done = 0; aw_done = 0; w_done = 0;
            m_phase = M_BUSY;
          end
        end
        default: begin
          if (!cur.wr) begin
            chk("arvalid", arvalid, !ar_done);
            chk("rready", rready, ar_done);
            chk("rd_awvalid", awvalid, 1'b0);
            chk("rd_wvalid", wvalid, 1'b0);
            chk("rd_bready", bready, 1'b0);
            if (arvalid) begin
              chk("araddr", araddr, cur.addr);
              chk("arsize", arsize, cur.size);
              chk("arid", arid, cur.is_data ? 4'd1 : 4'd0);
              chk("arlen", arlen, 8'd0);
              chk("arburst", arburst, 2'b01);
              last_araddr = araddr;
              last_arsize = arsize;
            end
            if (arvalid && arready) ar_done = 1;
            if (rready && rvalid) begin
              exp_rdata_o = rdata;
              m_phase = M_DONE;
            end
          end else begin
            chk("awvalid", awvalid, !aw_done);
            chk("wvalid", wvalid, !w_done);
            chk("bready", bready, aw_done && w_done);
            chk("wr_arvalid", arvalid, 1'b0);
            chk("wr_rready", rready, 1'b0);
            if (awvalid) begin
              chk("awaddr", awaddr, cur.addr);
              chk("awsize", awsize, cur.size);
              chk("awid", awid, 4'd1);
              chk("awlen", awlen, 8'd0);
              chk("awburst", awburst, 2'b01);
              last_awaddr = awaddr;
              last_awsize = awsize;
            end
            if (wvalid) begin
              chk("wdata", wdata, cur.wdata);
              chk("wstrb", wstrb, cur.wstrb);
              last_wdata = wdata;
              last_wstrb = wstrb;
            end
            if (!awvalid && wvalid) seen_w_only = 1;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            if (bready && bvalid) m_phase = M_DONE;
          end
        end
      endcase
    end
  end

  // ---------------- directed stimulus ----------------------------------------
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Counts falling edges up to and including the requested completion pulse.
  task automatic wait_ok(input bit want_data, output int n);
    n = 0;
    do begin
      @(negedge cpu_clk);
      n++;
    end while (!(want_data ? data_data_ok : inst_data_ok) && n < 200);
    chk(want_data ? "data_ok_timeout" : "inst_ok_timeout", n < 200, 1'b1);
  endtask

  int n, k, cnt0;

  initial begin
    cpu_rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'h0; data_wstrb = 4'h0; data_wdata = 32'h0;
    repeat (3) tick();
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    chk("reset_rdata_o", rdata_o, 32'h0);
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_awvalid", awvalid, 1'b0);
    chk("reset_i_stall", i_stall, 1'b0);
    tick();

    // 1: fetch with arready after two wait cycles
    ar_dly = 2; r_dly = 0; slv_rdata = 32'h3C08BFC0;
    cnt0 = inst_ok_cnt;
    inst_addr = 32'hBFC00000; inst_req = 1'b1;
    wait_ok(0, n);
    chk("t1_latency", n, 6);
    chk("t1_rdata_o", rdata_o, 32'h3C08BFC0);
    chk("t1_i_stall_at_ok", i_stall, 1'b0);
    chk("t1_araddr", last_araddr, 32'hBFC00000);
    chk("t1_arsize", last_arsize, 3'd2);
    tick(); inst_req = 1'b0;
    repeat (3) tick();
    chk("t1_ok_pulses", inst_ok_cnt - cnt0, 1);
    $display("txn 1: fetch 0xBFC00000 latency %0d rdata_o 0x%08h", n, rdata_o);

    // 2: simultaneous requests, data load wins
    ar_dly = 0; slv_rdata = 32'hA5A55A5A;
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80001000;
    inst_addr = 32'hBFC00004;
    data_req = 1'b1; inst_req = 1'b1;
    wait_ok(1, n);
    chk("t2_data_latency", n, 4);
    chk("t2_data_araddr", last_araddr, 32'h80001000);
    chk("t2_data_rdata_o", rdata_o, 32'hA5A55A5A);
    tick(); data_req = 1'b0; slv_rdata = 32'h24020001;
    k = 0;
    do begin @(negedge cpu_clk); k++; end while (!arvalid && k < 20);
    chk("t2_inst_ar_gap", k, 2);
    chk("t2_inst_araddr", araddr, 32'hBFC00004);
    wait_ok(0, n);
    chk("t2_inst_tail", n, 2);
    chk("t2_inst_rdata_o", rdata_o, 32'h24020001);
    tick(); inst_req = 1'b0;
    repeat (2) tick();
    $display("txn 2: data load then fetch, fetch AR gap %0d", k);

    // 3: byte store, AW accepted one cycle before W
    aw_dly = 0; w_dly = 1; b_dly = 0;
    seen_w_only = 0;
    data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h80000003;
    data_wstrb = 4'b1000; data_wdata = 32'h77000000;
    data_req = 1'b1;
    wait_ok(1, n);
    chk("t3_latency", n, 5);
    chk("t3_w_held_alone", seen_w_only, 1'b1);
    chk("t3_awaddr", last_awaddr, 32'h80000003);
    chk("t3_awsize", last_awsize, 3'd0);
    chk("t3_wstrb", last_wstrb, 4'b1000);
    tick(); data_req = 1'b0;
    repeat (2) tick();
    $display("txn 3: byte store latency %0d", n);

    // 4: word store, AW and W accepted together
    aw_dly = 0; w_dly = 0; b_dly = 0;
    seen_w_only = 0;
    cnt0 = data_ok_cnt;
    data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80000010;
    data_wstrb = 4'hF; data_wdata = 32'h12345678;
    data_req = 1'b1;
    wait_ok(1, n);
    chk("t4_latency", n, 4);
    chk("t4_no_w_only", seen_w_only, 1'b0);
    chk("t4_wdata", last_wdata, 32'h12345678);
    tick(); data_req = 1'b0;
    repeat (3) tick();
    chk("t4_ok_pulses", data_ok_cnt - cnt0, 1);
    $display("txn 4: word store latency %0d", n);

    // 5: reset while waiting for read data
    r_dly = 20; slv_rdata = 32'h0BADF00D;
    data_wr = 1'b0;
    inst_addr = 32'hBFC00008; inst_req = 1'b1;
    k = 0;
    do begin @(negedge cpu_clk); k++; end while (!rready && k < 20);
    chk("t5_reach_r", rready, 1'b1);
    chk("t5_stall_before", i_stall, 1'b1);
    tick(); cpu_rst = 1'b1;
    @(negedge cpu_clk);
    chk("t5_stall_in_rst", i_stall, 1'b0);
    tick(); cpu_rst = 1'b0; inst_req = 1'b0;
    @(negedge cpu_clk);
    chk("t5_rready_after", rready, 1'b0);
    chk("t5_arvalid_after", arvalid, 1'b0);
    chk("t5_rdata_o_after", rdata_o, 32'h0);
    r_dly = 0; slv_rdata = 32'h8FBF0010;
    tick(); inst_addr = 32'hBFC00010; inst_req = 1'b1;
    wait_ok(0, n);
    chk("t5_refetch_latency", n, 4);
    chk("t5_refetch_rdata_o", rdata_o, 32'h8FBF0010);
    tick(); inst_req = 1'b0;
    repeat (2) tick();
    $display("txn 5: reset mid-read, refetch latency %0d", n);

    // 6: requester inputs change after grant
    ar_dly = 3; slv_rdata = 32'h13572468;
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80002000;
    data_req = 1'b1;
    tick(); data_addr = 32'hDEADBEE0;
    wait_ok(1, n);
    chk("t6_load_latency", n, 6);
    chk("t6_araddr_held", last_araddr, 32'h80002000);
    tick(); data_req = 1'b0;
    repeat (2) tick();
    aw_dly = 2; w_dly = 0;
    data_wr = 1'b1; data_addr = 32'h80003000; data_wdata = 32'hCAFEF00D; data_wstrb = 4'hF;
    data_req = 1'b1;
    tick(); data_addr = 32'h0; data_wdata = 32'h0; data_wstrb = 4'h0;
    wait_ok(1, n);
    chk("t6_store_latency", n, 5);
    chk("t6_awaddr_held", last_awaddr, 32'h80003000);
    chk("t6_wdata_held", last_wdata, 32'hCAFEF00D);
    tick(); data_req = 1'b0;
    repeat (3) tick();
    $display("txn 6: late input changes, store latency %0d", n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
